spart_rx: RTL and testbench



---
 rtl/spart_rx_if.sv | 33 +++
 rtl/spart_rx.sv | 161 ++++++++++++++++
 tb/tb_spart_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/spart_rx_if.sv
// Bus-side signal bundle of the SPART receive engine: serial input, baud tick,
// read strobe and the received-byte status returned to the bus interface.
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic                 baud_tick;
    logic                 receive_read_en;
    logic [DATA_BITS-1:0] receive_read_line;
    logic                 rda;
    logic                 overrun;
    logic                 framing_err;

    modport master (
        output rxd,
        output baud_tick,
        output receive_read_en,
        input  receive_read_line,
        input  rda,
        input  overrun,
        input  framing_err
    );

    modport slave (
        input  rxd,
        input  baud_tick,
        input  receive_read_en,
        output receive_read_line,
        output rda,
        output overrun,
        output framing_err
    );
endinterface

// File: rtl/spart_rx.sv
// SPART receive engine: deserialises 8N1 frames from rxd using a 16x oversample tick.
// Define SPART_RX_FRAMING_CHECK_EN to discard frames with a low stop bit and flag framing_err.
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic      clk,
    input  logic      rst,
    spart_rx_if.slave bus
);

    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_TICKS = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] FULL_TICKS = TW'(OVERSAMPLE);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS);

`ifdef SPART_RX_FRAMING_CHECK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q;
    logic                 rxd_meta_q;
    logic                 rxd_s_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [TW-1:0]        tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q;
    logic [BW-1:0]        bit_cnt_d;
    logic [DATA_BITS-1:0] shift_reg_q;
    logic [DATA_BITS-1:0] shift_reg_d;
    logic [DATA_BITS-1:0] read_line_q;
    logic                 rda_q;
    logic                 overrun_q;
    logic                 tick_done;
    logic                 load_en;

    // rxd is asynchronous; everything downstream uses only the synchronised copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= bus.rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    assign tick_cnt_d  = tick_cnt_q + TW'(1);
    assign bit_cnt_d   = bit_cnt_q + BW'(1);
    assign shift_reg_d = {rxd_s_q, shift_reg_q[DATA_BITS-1:1]};
    assign tick_done   = bus.baud_tick && (tick_cnt_d == FULL_TICKS);

`ifdef SPART_RX_FRAMING_CHECK_EN
    logic framing_err_q;
    assign load_en         = (state_q == STOP) && tick_done && rxd_s_q;
    assign bus.framing_err = framing_err_q;
`else
    assign load_en         = (state_q == STOP) && tick_done;
    assign bus.framing_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_reg_q <= '0;
            read_line_q <= '0;
            rda_q       <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SPART_RX_FRAMING_CHECK_EN
            framing_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                    end
                end
                // Half a bit in, a high line means the low pulse was a glitch.
                START: begin
                    if (bus.baud_tick) begin
                        if (tick_cnt_d == HALF_TICKS) begin
                            if (rxd_s_q) begin
                                state_q <= IDLE;
                            end else begin
                                state_q    <= DATA;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end
                DATA: begin
                    if (bus.baud_tick) begin
                        if (tick_done) begin
                            shift_reg_q <= shift_reg_d;
                            bit_cnt_q   <= bit_cnt_d;
                            tick_cnt_q  <= '0;
                            if (bit_cnt_d == LAST_BIT) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end
                STOP: begin
                    if (bus.baud_tick) begin
                        if (tick_done) begin
                            tick_cnt_q <= '0;
`ifdef SPART_RX_FRAMING_CHECK_EN
                            if (!rxd_s_q) begin
                                framing_err_q <= 1'b1;
                                state_q       <= BREAK;
                            end else begin
                                state_q <= IDLE;
                            end
`else
                            state_q <= IDLE;
`endif
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end
`ifdef SPART_RX_FRAMING_CHECK_EN
                BREAK: begin
                    if (rxd_s_q) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase

            // A load wins over a same-cycle read; that read consumed the old byte, so no overrun.
            if (load_en) begin
                read_line_q <= shift_reg_q;
                rda_q       <= 1'b1;
                if (rda_q && !bus.receive_read_en) begin
                    overrun_q <= 1'b1;
                end
            end else if (bus.receive_read_en) begin
                rda_q     <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.receive_read_line = read_line_q;
    assign bus.rda               = rda_q;
    assign bus.overrun           = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed self-checking bench for spart_rx: 16x oversample, one baud tick every 4 clocks,
// one bit period = 64 clocks.
module tb_spart_rx;

    localparam int BIT_CLKS = 64;
    localparam int LOAD_TICK = 8 + 8 * 16 + 16;
`ifdef SPART_RX_FRAMING_CHECK_EN
    localparam bit FRAMING_EN = 1'b1;
`else
    localparam bit FRAMING_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   tickDiv;
    logic ferrExp;
    logic [7:0] lineAfterBad;
    logic rdaAfterBad;

    spart_rx_if #(.DATA_BITS(8)) bus ();

    spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud ticks change on the falling edge so the DUT samples them cleanly.
    initial begin
        tickDiv = 0;
        bus.baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tickDiv = (tickDiv + 1) % 4;
            bus.baud_tick = (tickDiv == 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic value, input int clks);
        bus.rxd = value;
        repeat (clks) @(negedge clk);
    endtask

    task automatic driveFrame(input logic [7:0] data, input bit stopLow);
        applyStimulus(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(data[i], BIT_CLKS);
        end
        if (stopLow) begin
            applyStimulus(1'b0, 40);
            applyStimulus(1'b1, 88);
        end else begin
            applyStimulus(1'b1, BIT_CLKS);
        end
    endtask

    // Start edge is seen 3 clocks later; the stop-bit sample lands on the LOAD_TICK-th tick after that.
    task automatic trackLoad(input logic [7:0] data, input bit stopLow, input bit readAtLoad,
                             input logic rdaPre, input logic expOverrun);
        int ticks;
        bit expLoad;
        expLoad = !(stopLow && FRAMING_EN);
        repeat (3) @(posedge clk);
        ticks = 0;
        while (ticks < LOAD_TICK) begin
            @(negedge clk);
            #1;
            if (bus.baud_tick) ticks++;
        end
        checkOutput("rda_before_load", {7'b0, bus.rda}, {7'b0, rdaPre});
        if (readAtLoad) bus.receive_read_en = 1'b1;
        @(posedge clk);
        #1;
        if (expLoad) begin
            checkOutput("rda_after_load", {7'b0, bus.rda}, 8'h01);
            checkOutput("line_after_load", bus.receive_read_line, data);
            checkOutput("overrun_after_load", {7'b0, bus.overrun}, {7'b0, expOverrun});
        end else begin
            ferrExp = 1'b1;
            checkOutput("rda_no_load", {7'b0, bus.rda}, {7'b0, rdaPre});
        end
        checkOutput("framing_err", {7'b0, bus.framing_err}, {7'b0, ferrExp});
        if (readAtLoad) begin
            @(negedge clk);
            bus.receive_read_en = 1'b0;
        end
    endtask

    task automatic sendFrame(input logic [7:0] data, input bit stopLow, input bit readAtLoad,
                             input logic rdaPre, input logic expOverrun);
        fork
            driveFrame(data, stopLow);
            trackLoad(data, stopLow, readAtLoad, rdaPre, expOverrun);
        join
    endtask

    task automatic doRead(input logic [7:0] expLine);
        bus.receive_read_en = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rda_after_read", {7'b0, bus.rda}, 8'h00);
        checkOutput("line_after_read", bus.receive_read_line, expLine);
        checkOutput("overrun_after_read", {7'b0, bus.overrun}, 8'h00);
        @(negedge clk);
        bus.receive_read_en = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_line"}, bus.receive_read_line, 8'h00);
        checkOutput({tag, "_rda"}, {7'b0, bus.rda}, 8'h00);
        checkOutput({tag, "_overrun"}, {7'b0, bus.overrun}, 8'h00);
        checkOutput({tag, "_framing_err"}, {7'b0, bus.framing_err}, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ferrExp = 1'b0;
        bus.rxd = 1'b1;
        bus.receive_read_en = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        sendFrame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        doRead(8'hA5);

        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        doRead(8'h3C);

        applyStimulus(1'b0, 20);
        applyStimulus(1'b1, 100);
        checkOutput("rda_false_start", {7'b0, bus.rda}, 8'h00);
        sendFrame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

        sendFrame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);

        applyStimulus(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, BIT_CLKS);
        applyStimulus(1'b1, 32);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("midframe_reset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 100);

        sendFrame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        doRead(8'h55);

        sendFrame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        lineAfterBad = FRAMING_EN ? 8'h55 : 8'h81;
        rdaAfterBad = !FRAMING_EN;
        checkOutput("line_after_bad_stop", bus.receive_read_line, lineAfterBad);
        checkOutput("rda_after_bad_stop", {7'b0, bus.rda}, {7'b0, rdaAfterBad});
        sendFrame(8'h42, 1'b0, 1'b0, rdaAfterBad, rdaAfterBad);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
